// File: rtl/xnor_popcount_acc_pkg.sv
// Purpose : shared BNN definitions (widths, accumulator FSM states, popcount helper).
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: XNOR_W / ACC_W / PC_W widths, acc_state_t, popcount().
package bnn_pkg;

  localparam int XNOR_W = 7;  // bits per XNOR match chunk
  localparam int ACC_W  = 8;  // accumulator / threshold width
  localparam int PC_W   = 3;  // popcount width for one chunk

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_t;

  // Behavioural popcount for BNN blocks that do not need an explicit tree.
  function automatic logic [PC_W-1:0] popcount(input logic [XNOR_W-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < XNOR_W; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/xnor_popcount_acc_if.sv
// Purpose : beat-in / result-out handshake bundle of the XNOR popcount accumulator.
// Latency : n/a (wiring only).
// Backpr. : valid/ready on both sides; master = producer+consumer side, slave = accumulator.
// Signals : in_valid/in_ready/x_in/in_last/threshold, out_valid/out_ready/out_bit/out_sum/out_beats/out_ovf.
interface xnor_popcount_acc_if #(
  parameter int WIDTH = bnn_pkg::XNOR_W,
  parameter int SUM_W = bnn_pkg::ACC_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_in;
  logic             in_last;
  logic [SUM_W-1:0] threshold;

  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic [SUM_W-1:0] out_sum;
  logic [SUM_W-1:0] out_beats;
  logic             out_ovf;

  modport master (
    output in_valid, x_in, in_last, threshold, out_ready,
    input  in_ready, out_valid, out_bit, out_sum, out_beats, out_ovf
  );

  modport slave (
    input  in_valid, x_in, in_last, threshold, out_ready,
    output in_ready, out_valid, out_bit, out_sum, out_beats, out_ovf
  );

endinterface

// File: rtl/xnor_popcount_acc_popcount7.sv
// Purpose : combinational 7-bit popcount as a two-level adder tree.
// Latency : 0 cycles (pure combinational).
// Backpr. : none.
// Ports   : i_x (7 match bits) -> o_cnt (0..7).
module popcount7
  import bnn_pkg::*;
(
  input  logic [XNOR_W-1:0] i_x,
  output logic [PC_W-1:0]   o_cnt
);

  // Two 3-input full-adder style groups, then combine with the odd bit.
  logic [1:0] w_grp_a;
  logic [1:0] w_grp_b;

  assign w_grp_a = 2'(i_x[0]) + 2'(i_x[1]) + 2'(i_x[2]);
  assign w_grp_b = 2'(i_x[3]) + 2'(i_x[4]) + 2'(i_x[5]);
  assign o_cnt   = PC_W'(w_grp_a) + PC_W'(w_grp_b) + PC_W'(i_x[6]);

endmodule

// File: rtl/xnor_popcount_acc.sv
// Purpose : accumulate per-beat XNOR popcounts over a neuron, threshold on the last beat.
// Latency : result registered, visible 1 cycle after the in_last beat is accepted.
// Backpr. : in_ready low while a result waits in DONE (one bubble per neuron); result held until out_ready.
// Ports   : clk, reset (sync, active-high), bus (xnor_popcount_acc_if.slave).
// Config  : XNOR_ACC_SAT_EN -> saturating accumulator with sticky overflow on out_ovf;
//           undefined -> accumulator wraps modulo 2^SUM_W and out_ovf is tied low.
module xnor_popcount_acc #(
  parameter int WIDTH = bnn_pkg::XNOR_W,
  parameter int SUM_W = bnn_pkg::ACC_W,
  parameter int PC_W  = bnn_pkg::PC_W
) (
  input  logic                 clk,
  input  logic                 reset,
  xnor_popcount_acc_if.slave   bus
);

  import bnn_pkg::*;

  acc_state_t       r_state;
  acc_state_t       w_state_nxt;
  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] r_beats;
  logic [SUM_W-1:0] r_out_sum;
  logic [SUM_W-1:0] r_out_beats;
  logic             r_out_bit;

  logic [PC_W-1:0]  w_pc;
  logic             w_accept;
  logic [SUM_W-1:0] w_acc_add;   // acc + pc after wrap or saturation
  logic [SUM_W-1:0] w_beats_inc;

  popcount7 u_popcount7 (
    .i_x   (bus.x_in),
    .o_cnt (w_pc)
  );

  assign w_accept    = bus.in_valid && (r_state == ACC);
  assign w_beats_inc = r_beats + SUM_W'(1);

`ifdef XNOR_ACC_SAT_EN
  logic [SUM_W:0] w_sum_ext;
  logic           w_sat;
  logic           r_ovf;
  logic           r_out_ovf;

  // One extra bit catches the carry; any carry clamps to all-ones.
  assign w_sum_ext = {1'b0, r_acc} + (SUM_W+1)'(w_pc);
  assign w_sat     = w_sum_ext[SUM_W];
  assign w_acc_add = w_sat ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
  assign bus.out_ovf = r_out_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf     <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (w_accept) begin
      if (bus.in_last) begin
        r_out_ovf <= r_ovf | w_sat;  // last beat may itself saturate
        r_ovf     <= 1'b0;
      end else begin
        r_ovf     <= r_ovf | w_sat;
      end
    end
  end
`else
  assign w_acc_add   = r_acc + SUM_W'(w_pc);
  assign bus.out_ovf = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (w_accept && bus.in_last) w_state_nxt = DONE;
      DONE:    if (bus.out_ready)           w_state_nxt = ACC;
      default: w_state_nxt = ACC;
    endcase
  end

  // Accumulator and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_beats     <= '0;
      r_out_sum   <= '0;
      r_out_beats <= '0;
      r_out_bit   <= 1'b0;
    end else if (w_accept) begin
      if (bus.in_last) begin
        r_out_sum   <= w_acc_add;
        r_out_beats <= w_beats_inc;
        r_out_bit   <= (w_acc_add >= bus.threshold);
        r_acc       <= '0;
        r_beats     <= '0;
      end else begin
        r_acc       <= w_acc_add;
        r_beats     <= w_beats_inc;
      end
    end
  end

  assign bus.in_ready  = (r_state == ACC);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_bit   = r_out_bit;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_beats = r_out_beats;

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Purpose : self-checking bench for xnor_popcount_acc with a sum-of-popcounts reference model.
// Latency : n/a.
// Backpr. : bench drives random out_ready stalls and input gaps.
module tb_xnor_popcount_acc;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef logic [6:0] beat_q_t[$];

  always #5 clk = ~clk;

  xnor_popcount_acc_if bus ();

  xnor_popcount_acc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: neuron result from the total number of agreeing bits.
  function automatic void model(input beat_q_t xs, input int thr,
                                output int s, output int n, output int b, output int o);
    int total;
    total = 0;
    foreach (xs[i]) total += $countones(xs[i]);
`ifdef XNOR_ACC_SAT_EN
    s = (total > 255) ? 255 : total;
    o = (total > 255) ? 1 : 0;
`else
    s = total % 256;
    o = 0;
`endif
    n = xs.size() % 256;
    b = (s >= thr) ? 1 : 0;
  endfunction

  // Sends the beats; last one flagged in_last when do_last. Returns #1 after final accept edge.
  task automatic drive_neuron(input beat_q_t xs, input logic [7:0] thr, input int max_gap,
                              input bit do_last);
    for (int i = 0; i < xs.size(); i++) begin
      int gap;
      int t;
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gap) tick();
      bus.in_valid  = 1'b1;
      bus.x_in      = xs[i];
      bus.in_last   = do_last && (i == xs.size() - 1);
      bus.threshold = thr;
      t = 0;
      while (bus.in_ready !== 1'b1 && t < 64) begin
        tick();
        t++;
      end
      if (t >= 64) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout in_ready=%b required 1", bus.in_ready);
      end
      tick();
      // Garbage on the idle bus must be ignored.
      bus.in_valid  = 1'b0;
      bus.x_in      = 7'($urandom);
      bus.in_last   = 1'($urandom);
      bus.threshold = 8'($urandom);
    end
  endtask

  task automatic drain(input int max_wait);
    repeat ($urandom_range(0, max_wait)) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++;
    if ({bus.out_bit, bus.out_sum, bus.out_beats, bus.out_ovf} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got bit=%b sum=%0d beats=%0d ovf=%b want all 0",
               bus.out_bit, bus.out_sum, bus.out_beats, bus.out_ovf);
    end
  endtask

  task automatic test_basic();
    beat_q_t xs;
    logic [7:0] thr_tab[3];
    xs = '{7'b1111111, 7'b0000000, 7'b1010101};
    thr_tab = '{8'd10, 8'd12, 8'd11};
    foreach (thr_tab[k]) begin
      drive_neuron(xs, thr_tab[k], 0, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", bus.out_valid); end
      n_checks++;
      if (bus.out_sum !== 8'd11) begin n_fail++; $display("FAIL basic_sum got %0d want 11", bus.out_sum); end
      n_checks++;
      if (bus.out_beats !== 8'd3) begin n_fail++; $display("FAIL basic_beats got %0d want 3", bus.out_beats); end
      n_checks++;
      if (bus.out_bit !== (thr_tab[k] <= 8'd11)) begin
        n_fail++;
        $display("FAIL basic_bit thr=%0d got %b want %b", thr_tab[k], bus.out_bit, thr_tab[k] <= 8'd11);
      end
      drain(0);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_drain got rdy=%b vld=%b want 1/0", bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_single_hold();
    beat_q_t xs;
    xs = '{7'b0000001};
    drive_neuron(xs, 8'd0, 0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid  = c[0];
      bus.x_in      = 7'b1111111;
      bus.in_last   = 1'b1;
      bus.threshold = 8'd200;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_handshake cyc=%0d got vld=%b rdy=%b want 1/0", c, bus.out_valid, bus.in_ready);
      end
      n_checks++;
      if (bus.out_sum !== 8'd1 || bus.out_beats !== 8'd1 || bus.out_bit !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_result cyc=%0d got sum=%0d beats=%0d bit=%b want 1/1/1",
                 c, bus.out_sum, bus.out_beats, bus.out_bit);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    drain(0);
    // Pulses during DONE must not have started a neuron.
    xs = '{7'b0000011};
    drive_neuron(xs, 8'd2, 0, 1'b1);
    n_checks++;
    if (bus.out_sum !== 8'd2 || bus.out_beats !== 8'd1) begin
      n_fail++;
      $display("FAIL hold_no_leak got sum=%0d beats=%0d want 2/1", bus.out_sum, bus.out_beats);
    end
    drain(0);
  endtask

  task automatic test_reset_mid();
    beat_q_t xs;
    xs = '{7'b1111111, 7'b0110110};
    drive_neuron(xs, 8'd0, 3, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.out_bit, bus.out_sum, bus.out_beats, bus.out_ovf} !== 19'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_outputs got vld=%b bit=%b sum=%0d beats=%0d rdy=%b want 0/0/0/0/1",
               bus.out_valid, bus.out_bit, bus.out_sum, bus.out_beats, bus.in_ready);
    end
    xs = '{7'b0000011};
    drive_neuron(xs, 8'd2, 2, 1'b1);
    n_checks++;
    if (bus.out_sum !== 8'd2 || bus.out_bit !== 1'b1 || bus.out_beats !== 8'd1) begin
      n_fail++;
      $display("FAIL midreset_next got sum=%0d bit=%b beats=%0d want 2/1/1",
               bus.out_sum, bus.out_bit, bus.out_beats);
    end
    // Reset while a result is pending in DONE.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 8'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL donereset got vld=%b sum=%0d rdy=%b want 0/0/1", bus.out_valid, bus.out_sum, bus.in_ready);
    end
  endtask

  task automatic test_overflow();
    beat_q_t xs;
    xs = {};
    repeat (37) xs.push_back(7'b1111111);
    drive_neuron(xs, 8'd255, 0, 1'b1);
`ifdef XNOR_ACC_SAT_EN
    n_checks++;
    if (bus.out_sum !== 8'd255 || bus.out_bit !== 1'b1 || bus.out_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sat got sum=%0d bit=%b ovf=%b want 255/1/1", bus.out_sum, bus.out_bit, bus.out_ovf);
    end
`else
    n_checks++;
    if (bus.out_sum !== 8'd3 || bus.out_bit !== 1'b0 || bus.out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_wrap got sum=%0d bit=%b ovf=%b want 3/0/0", bus.out_sum, bus.out_bit, bus.out_ovf);
    end
`endif
    n_checks++;
    if (bus.out_beats !== 8'd37) begin n_fail++; $display("FAIL ovf_beats got %0d want 37", bus.out_beats); end
    drain(2);
    xs = '{7'b0000001};
    drive_neuron(xs, 8'd0, 0, 1'b1);
    n_checks++;
    if (bus.out_ovf !== 1'b0 || bus.out_sum !== 8'd1) begin
      n_fail++;
      $display("FAIL ovf_cleared got ovf=%b sum=%0d want 0/1", bus.out_ovf, bus.out_sum);
    end
    drain(0);
  endtask

  // Random neurons, random gaps and stalls; some long enough to wrap or saturate.
  task automatic test_random(input int count, input int max_gap, input int max_stall);
    for (int k = 0; k < count; k++) begin
      beat_q_t xs;
      int len, thr, es, en, eb, eo;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 45) : $urandom_range(1, 12);
      xs = {};
      repeat (len) xs.push_back(7'($urandom));
      thr = $urandom_range(0, 255);
      model(xs, thr, es, en, eb, eo);
      drive_neuron(xs, 8'(thr), max_gap, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'(es) || bus.out_beats !== 8'(en)) begin
        n_fail++;
        $display("FAIL rand_result n=%0d got vld=%b sum=%0d beats=%0d want 1/%0d/%0d",
                 k, bus.out_valid, bus.out_sum, bus.out_beats, es, en);
      end
      n_checks++;
      if (bus.out_bit !== 1'(eb) || bus.out_ovf !== 1'(eo)) begin
        n_fail++;
        $display("FAIL rand_flags n=%0d thr=%0d got bit=%b ovf=%b want %0d/%0d",
                 k, thr, bus.out_bit, bus.out_ovf, eb, eo);
      end
      drain(max_stall);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.x_in        = '0;
    bus.in_last     = 1'b0;
    bus.threshold   = '0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_basic();
    test_single_hold();
    test_reset_mid();
    test_overflow();
    test_random(25, 2, 3);   // gaps and stalls
    test_random(15, 0, 0);   // back-to-back
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
